input_serial_to_parallel: RTL and testbench
===========================================

Name: input_serial_to_parallel

Overview:
- Receive-side counterpart of the chip's serial readout path.
- Deserialises a 1-bit, one-bit-per-clock, LSB-first serial stream into WIDTH_OUTPUT-bit parallel words.
- Presents each completed word on a valid/ready holding register.
- Sits at the readout link input, feeding downstream capture/processing logic; tracks overrun and frame-alignment errors as sticky flags.

Parameters:
- WIDTH_OUTPUT, 128, word width in bits; legal range >= 2.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- serial_in  input  1  serial data; one bit sampled every CLK edge.
- sync  input  1  frame marker; high means this cycle's serial_in is bit 0 of a new word.
- data_ready  input  1  consumer accepts data_out on an edge where data_valid=1.
- status_clr  input  1  clears the overrun and align_err sticky flags.
- data_out  output  WIDTH_OUTPUT  last completed word; bit k = k-th sampled bit.
- data_valid  output  1  data_out holds an unaccepted word.
- overrun  output  1  sticky; a completed word was dropped.
- align_err  output  1  sticky; sync arrived with a partial word in progress.
- frame_count  output  16  only with FRAME_COUNT_EN; see Optional Feature.

Behaviour:
- Reset (RST_N=0 at edge): bit_cnt=0, assembly register=0, data_out=0, data_valid=0, overrun=0, align_err=0, frame_count=0.
- Reset overrides all other inputs; a partial word in progress at reset is discarded.
- bit_cnt is $clog2(WIDTH_OUTPUT)+1 bits wide and counts 0..WIDTH_OUTPUT-1.
- Free-running: with no sync, the first sample after reset release is bit 0.
- Every non-reset edge: asm[idx] <= serial_in, where idx = 0 if sync=1, else bit_cnt.
- sync=1:
  - bit_cnt <= 1.
  - If bit_cnt != 0, the partial word is abandoned and align_err <= 1.
  - sync with bit_cnt==0 is legal and sets no error.
- sync=0 and bit_cnt < WIDTH_OUTPUT-1: bit_cnt <= bit_cnt+1.
- sync=0 and bit_cnt == WIDTH_OUTPUT-1: word completes, bit_cnt <= 0. The completed word is {serial_in, asm[WIDTH_OUTPUT-2:0]}.
- Latency: the word appears on data_out with data_valid=1 in the cycle after the edge that samples its last bit.
- Word load on completion:
  - data_valid=0: data_out <= word, data_valid <= 1.
  - data_valid=1 and data_ready=1: accept and reload in the same edge; data_out <= word, data_valid stays 1.
  - data_valid=1 and data_ready=0: word dropped, data_out unchanged, overrun <= 1.
- No completion, data_valid=1 and data_ready=1: data_valid <= 0; data_out holds its value.
- data_ready while data_valid=0 is ignored.
- status_clr=1 clears overrun and align_err. If a set condition occurs on the same edge, set wins.
- data_out changes only on a load; data_valid never deasserts without data_ready.

Optional Feature:
- Macro FRAME_COUNT_EN.
- Defined:
  - frame_count port exists: a 16-bit counter incremented on every word completion, dropped words included.
  - Wraps 0xFFFF -> 0x0000.
  - Cleared by reset only; status_clr does not affect it.
- Undefined: no frame_count port and no counter logic; all other behaviour identical.

Test Plan (WIDTH_OUTPUT=8 unless noted):
- Reset: hold RST_N=0 with random serial_in/sync/data_ready for 5 cycles -> data_out=0x00, data_valid=0, overrun=0, align_err=0.
- Single word: release reset, drive sync=1 with bit0, then 0xA5 LSB-first (1,0,1,0,0,1,0,1), data_ready=0 -> data_valid=1 with data_out=0xA5 the cycle after bit 7; data_valid still 1 ten cycles later; one cycle with data_ready=1 -> data_valid=0.
- Back-to-back: data_ready=1 constant, stream 0x3C, 0xFF, 0x01 contiguously -> three single-cycle valid beats with those values, exactly 8 cycles apart, no overrun.
- Overrun: data_ready=0, stream 0x11 then 0x22 -> data_out stays 0x11, overrun=1 after the 0x22 completes. status_clr pulse -> overrun=0. status_clr coincident with a new drop -> overrun stays 1.
- Misalignment: sync after 3 bits of a word, then stream 0x5A -> align_err=1, no word from the partial, next word=0x5A.
- Mid-word reset and counter:
  - Assert RST_N=0 after 4 bits -> all outputs return to reset values; a subsequent full 0xC3 word is received correctly.
  - With FRAME_COUNT_EN, stream 3 words -> frame_count=3.
  - Preload by forcing 0xFFFF; one more word -> frame_count=0x0000.

Source files
------------

// File: rtl/input_serial_to_parallel.sv
// LSB-first serial-to-parallel receiver with a valid/ready output register and sticky error flags.
// Define FRAME_COUNT_EN to add a 16-bit frame_count output that counts every completed word.
module input_serial_to_parallel #(
  parameter int WIDTH_OUTPUT = 128
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    serial_in,
  input  logic                    sync,
  input  logic                    data_ready,
  input  logic                    status_clr,
  output logic [WIDTH_OUTPUT-1:0] data_out,
  output logic                    data_valid,
  output logic                    overrun,
`ifdef FRAME_COUNT_EN
  output logic [15:0]             frame_count,
`endif
  output logic                    align_err
);

  localparam int CNT_W = $clog2(WIDTH_OUTPUT) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH_OUTPUT - 1);

  logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
  // The final bit of a word is taken straight from serial_in, so only W-1 bits are stored.
  logic [WIDTH_OUTPUT-2:0] asm_reg, asm_next;
  logic [WIDTH_OUTPUT-1:0] data_reg, data_next;
  logic                    valid_reg, valid_next;
  logic                    overrun_reg, overrun_next;
  logic                    align_reg, align_next;
  logic [CNT_W-1:0]        idx;
  logic                    completing, load, drop, align_set;
  logic [WIDTH_OUTPUT-1:0] word_done;

  assign idx        = sync ? '0 : bit_cnt_reg;
  assign completing = !sync && (bit_cnt_reg == LAST_BIT);
  assign word_done  = {serial_in, asm_reg};
  assign load       = completing && (!valid_reg || data_ready);
  assign drop       = completing && valid_reg && !data_ready;
  assign align_set  = sync && (bit_cnt_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH_OUTPUT - 1; gi++) begin : g_asm
      assign asm_next[gi] = (idx == CNT_W'(gi)) ? serial_in : asm_reg[gi];
    end
  endgenerate

  always_comb begin
    bit_cnt_next = bit_cnt_reg + 1'b1;
    if (sync)
      bit_cnt_next = CNT_W'(1);
    else if (bit_cnt_reg == LAST_BIT)
      bit_cnt_next = '0;

    data_next  = load ? word_done : data_reg;
    valid_next = valid_reg;
    if (load)
      valid_next = 1'b1;
    else if (!completing && valid_reg && data_ready)
      valid_next = 1'b0;

    // A set condition on the same edge as status_clr wins.
    overrun_next = drop ? 1'b1 : (status_clr ? 1'b0 : overrun_reg);
    align_next   = align_set ? 1'b1 : (status_clr ? 1'b0 : align_reg);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bit_cnt_reg <= '0;
      asm_reg     <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      align_reg   <= 1'b0;
    end else begin
      bit_cnt_reg <= bit_cnt_next;
      asm_reg     <= asm_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
      align_reg   <= align_next;
    end
  end

  assign data_out   = data_reg;
  assign data_valid = valid_reg;
  assign overrun    = overrun_reg;
  assign align_err  = align_reg;

`ifdef FRAME_COUNT_EN
  logic [15:0] frame_count_reg;

  // Counts dropped words too; only reset clears it.
  always_ff @(posedge CLK) begin
    if (!RST_N)
      frame_count_reg <= '0;
    else if (completing)
      frame_count_reg <= frame_count_reg + 16'd1;
  end

  assign frame_count = frame_count_reg;
`endif

endmodule

// File: tb/tb_input_serial_to_parallel.sv
// Self-checking bench for input_serial_to_parallel (WIDTH_OUTPUT=8) with a queue-based reference model.
module tb_input_serial_to_parallel;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       serial_in = 1'b0;
  logic       sync = 1'b0;
  logic       data_ready = 1'b0;
  logic       status_clr = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       overrun;
  logic       align_err;
`ifdef FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bits of the word in progress, plus the holding register and flags.
  logic       m_bits[$];
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_al = 1'b0;
  logic [15:0] m_fc = 16'h0000;

  input_serial_to_parallel #(.WIDTH_OUTPUT(8)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .serial_in(serial_in),
    .sync(sync),
    .data_ready(data_ready),
    .status_clr(status_clr),
    .data_out(data_out),
    .data_valid(data_valid),
    .overrun(overrun),
`ifdef FRAME_COUNT_EN
    .frame_count(frame_count),
`endif
    .align_err(align_err)
  );

  always #5 CLK = ~CLK;

  // One clock: drive inputs, take the edge, advance the model, settle 1 time unit past the edge.
  task automatic cyc(input logic r, input logic s, input logic d, input logic rdy, input logic clr);
    int  wv;
    logic done, set_o, set_a;
    RST_N = r; sync = s; serial_in = d; data_ready = rdy; status_clr = clr;
    @(posedge CLK);
    if (!r) begin
      m_bits.delete();
      m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_al = 1'b0; m_fc = 16'h0000;
    end else begin
      done = 1'b0; set_o = 1'b0; set_a = 1'b0; wv = 0;
      if (s) begin
        if (m_bits.size() != 0) set_a = 1'b1;
        m_bits.delete();
      end
      m_bits.push_back(d);
      if (m_bits.size() == 8) begin
        for (int k = 0; k < 8; k++) wv += int'(m_bits[k]) << k;
        done = 1'b1;
        m_bits.delete();
      end
      if (done) begin
        m_fc = m_fc + 16'd1;
        if (!m_valid || rdy) begin
          m_data = wv[7:0]; m_valid = 1'b1;
        end else set_o = 1'b1;
      end else if (m_valid && rdy) m_valid = 1'b0;
      m_ovr = set_o ? 1'b1 : (clr ? 1'b0 : m_ovr);
      m_al  = set_a ? 1'b1 : (clr ? 1'b0 : m_al);
    end
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic sync_first, input logic rdy);
    for (int j = 0; j < 8; j++) cyc(1'b1, sync_first && (j == 0), w[j], rdy, 1'b0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", data_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (align_err !== 1'b0) begin n_err++; $display("FAIL reset_align: got %b want 0", align_err); end
  endtask

  task automatic test_single_word();
    logic [7:0] w = 8'hA5;
    for (int j = 0; j < 8; j++) begin
      cyc(1'b1, j == 0, w[j], 1'b0, 1'b0);
      if (j == 6) begin
        n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got valid %b want 0", data_valid); end
      end
    end
    n_cmp++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", data_valid); end
    n_cmp++; if (data_out !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", data_out); end
    n_cmp++; if (align_err !== 1'b0) begin n_err++; $display("FAIL single_align: got %b want 0", align_err); end
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL single_hold: got %b want 1", data_valid); end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL single_accept: got %b want 0", data_valid); end
    n_cmp++; if (data_out !== 8'hA5) begin n_err++; $display("FAIL single_keep: got %h want a5", data_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[3] = '{8'h3C, 8'hFF, 8'h01};
    logic [7:0] seen[$];
    int         at[$];
    do_reset();
    for (int c = 0; c < 24; c++) begin
      cyc(1'b1, 1'b0, words[c / 8][c % 8], 1'b1, 1'b0);
      if (data_valid === 1'b1) begin seen.push_back(data_out); at.push_back(c); end
    end
    n_cmp++; if (seen.size() != 3) begin n_err++; $display("FAIL b2b_beats: got %0d want 3", seen.size()); end
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      n_cmp++; if (seen[i] !== words[i]) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", i, seen[i], words[i]); end
      n_cmp++; if (at[i] != 7 + 8 * i) begin n_err++; $display("FAIL b2b_cycle%0d: got %0d want %0d", i, at[i], 7 + 8 * i); end
    end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_overrun();
    do_reset();
    send_word(8'h11, 1'b0, 1'b0);
    n_cmp++; if (data_out !== 8'h11) begin n_err++; $display("FAIL ovr_first: got %h want 11", data_out); end
    send_word(8'h22, 1'b0, 1'b0);
    n_cmp++; if (data_out !== 8'h11) begin n_err++; $display("FAIL ovr_keep: got %h want 11", data_out); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", overrun); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clr: got %b want 0", overrun); end
    for (int j = 1; j < 8; j++) cyc(1'b1, 1'b0, 1'b1, 1'b0, j == 7);
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
    n_cmp++; if (data_out !== 8'h11) begin n_err++; $display("FAIL ovr_keep2: got %h want 11", data_out); end
  endtask

  task automatic test_misalign();
    logic [7:0] w = 8'h5A;
    do_reset();
    for (int j = 0; j < 3; j++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      cyc(1'b1, j == 0, w[j], 1'b0, 1'b0);
      if (j == 0) begin
        n_cmp++; if (align_err !== 1'b1) begin n_err++; $display("FAIL mis_align: got %b want 1", align_err); end
      end
      if (j == 6) begin
        n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL mis_partial: got valid %b want 0", data_valid); end
      end
    end
    n_cmp++; if (data_out !== 8'h5A || data_valid !== 1'b1) begin
      n_err++; $display("FAIL mis_word: got %h/%b want 5a/1", data_out, data_valid);
    end
  endtask

  task automatic test_midword_reset();
    do_reset();
    send_word(8'h77, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (data_out !== 8'h00 || data_valid !== 1'b0 || overrun !== 1'b0 || align_err !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: got %h/%b/%b/%b want 00/0/0/0", data_out, data_valid, overrun, align_err);
    end
    send_word(8'hC3, 1'b0, 1'b0);
    n_cmp++; if (data_out !== 8'hC3 || data_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_word: got %h/%b want c3/1", data_out, data_valid);
    end
  endtask

`ifdef FRAME_COUNT_EN
  task automatic test_frame_count();
    do_reset();
    send_word(8'h01, 1'b0, 1'b1);
    send_word(8'h02, 1'b0, 1'b0);
    send_word(8'h03, 1'b0, 1'b0);
    n_cmp++; if (frame_count !== 16'd3) begin n_err++; $display("FAIL fc_three: got %h want 0003", frame_count); end
    force dut.frame_count_reg = 16'hFFFF;
    #1;
    release dut.frame_count_reg;
    m_fc = 16'hFFFF;
    send_word(8'h04, 1'b0, 1'b0);
    n_cmp++; if (frame_count !== 16'h0000) begin n_err++; $display("FAIL fc_wrap: got %h want 0000", frame_count); end
  endtask
`endif

  task automatic test_random();
    logic r, s, d, rdy, clr;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 99) != 0);
      s   = ($urandom_range(0, 11) == 0);
      d   = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 9) == 0);
      cyc(r, s, d, rdy, clr);
      n_cmp++; if (data_out !== m_data || data_valid !== m_valid || overrun !== m_ovr || align_err !== m_al) begin
        n_err++;
        $display("FAIL rand_%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i, data_out, data_valid, overrun, align_err,
                 m_data, m_valid, m_ovr, m_al);
      end
`ifdef FRAME_COUNT_EN
      n_cmp++; if (frame_count !== m_fc) begin n_err++; $display("FAIL rand_fc_%0d: got %h want %h", i, frame_count, m_fc); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overrun();
    test_misalign();
    test_midword_reset();
`ifdef FRAME_COUNT_EN
    test_frame_count();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
